// File: rtl/uart_pkg.sv
// Shared UART definitions: RX state encodings, parity types, legal prescale values.
package uart_pkg;

  localparam int unsigned DataWidthDef = 8;
  localparam int unsigned PrescaleWDef = 6;

  localparam logic ParEven = 1'b0;
  localparam logic ParOdd  = 1'b1;

  localparam int unsigned Prescale8  = 8;
  localparam int unsigned Prescale16 = 16;
  localparam int unsigned Prescale32 = 32;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  function automatic logic prescale_legal(input int unsigned p);
    return (p == Prescale8) || (p == Prescale16) || (p == Prescale32);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX bit timing: edge/bit counters and sample strobe at mid-bit.
// UART_RX_MAJ_VOTE_EN selects a 3-sample majority vote around the mid point.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned PrescaleW = PrescaleWDef,
  parameter int unsigned BitCntW   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 active_i,
  input  logic                 start_i,
  input  logic                 rx_i,
  input  logic [PrescaleW-1:0] prescale_i,
  output logic [BitCntW-1:0]   bit_cnt_o,
  output logic                 bit_end_o,
  output logic                 sample_vld_o,
  output logic                 sample_bit_o
);

  logic [PrescaleW-1:0] edge_cnt_q, edge_cnt_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PrescaleW-1:0] mid, last;

  assign mid       = prescale_i >> 1;
  assign last      = prescale_i - PrescaleW'(1);
  assign bit_end_o = active_i && (edge_cnt_q == last);
  assign bit_cnt_o = bit_cnt_q;

  // The start-detect cycle is edge 0, so counting resumes at 1.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (!active_i) begin
      edge_cnt_d = start_i ? PrescaleW'(1) : '0;
      bit_cnt_d  = '0;
    end else if (edge_cnt_q == last) begin
      edge_cnt_d = '0;
      bit_cnt_d  = bit_cnt_q + BitCntW'(1);
    end else begin
      edge_cnt_d = edge_cnt_q + PrescaleW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

`ifdef UART_RX_MAJ_VOTE_EN
  logic [1:0] smp_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      smp_q <= '0;
    end else if (active_i) begin
      if (edge_cnt_q == mid - PrescaleW'(1)) smp_q[0] <= rx_i;
      if (edge_cnt_q == mid) smp_q[1] <= rx_i;
    end
  end

  assign sample_vld_o = active_i && (edge_cnt_q == mid + PrescaleW'(1));
  assign sample_bit_o = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_i) | (smp_q[1] & rx_i);
`else
  assign sample_vld_o = active_i && (edge_cnt_q == mid);
  assign sample_bit_o = rx_i;
`endif

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: frame FSM, LSB-first shift register, parity/stop checks.
// Bit sampling (optionally majority-voted via UART_RX_MAJ_VOTE_EN) lives in uart_rx_sampler.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int unsigned DataWidth = DataWidthDef,
  parameter int unsigned PrescaleW = PrescaleWDef
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 rx_in_i,
  input  logic                 par_en_i,
  input  logic                 par_typ_i,
  input  logic [PrescaleW-1:0] prescale_i,
  output logic [DataWidth-1:0] p_data_o,
  output logic                 data_valid_o,
  output logic                 par_err_o,
  output logic                 stp_err_o,
  output logic                 busy_o
);

  localparam int unsigned BitCntW = $clog2(DataWidth + 3);

  rx_state_e            state_q;
  logic [PrescaleW-1:0] prescale_q;
  logic                 par_en_q, par_typ_q, par_bad_q, stp_bad_q;
  logic [DataWidth-1:0] shift_q, p_data_q;
  logic                 data_valid_q, par_err_q, stp_err_q, busy_q;

  logic [BitCntW-1:0]   bit_cnt;
  logic                 bit_end, sample_vld, sample_bit, active, start, par_exp;

  assign active  = (state_q != StIdle);
  assign start   = (state_q == StIdle) && !rx_in_i;
  assign par_exp = (par_typ_q == ParEven) ? ^shift_q : ~^shift_q;

  uart_rx_sampler #(
    .PrescaleW (PrescaleW),
    .BitCntW   (BitCntW)
  ) u_sampler (
    .CLK          (CLK),
    .RST          (RST),
    .active_i     (active),
    .start_i      (start),
    .rx_i         (rx_in_i),
    .prescale_i   (prescale_q),
    .bit_cnt_o    (bit_cnt),
    .bit_end_o    (bit_end),
    .sample_vld_o (sample_vld),
    .sample_bit_o (sample_bit)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      prescale_q   <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      stp_bad_q    <= 1'b0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!rx_in_i) begin
            state_q    <= StStart;
            busy_q     <= 1'b1;
            prescale_q <= prescale_i;
            par_en_q   <= par_en_i;
            par_typ_q  <= par_typ_i;
            par_bad_q  <= 1'b0;
            stp_bad_q  <= 1'b0;
          end
        end
        StStart: begin
          if (sample_vld && sample_bit) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (bit_end) begin
            state_q <= StData;
          end
        end
        StData: begin
          if (sample_vld) shift_q <= {sample_bit, shift_q[DataWidth-1:1]};
          if (bit_end && (bit_cnt == BitCntW'(DataWidth))) begin
            state_q <= par_en_q ? StParity : StStop;
          end
        end
        StParity: begin
          if (sample_vld) par_bad_q <= (sample_bit != par_exp);
          if (bit_end) state_q <= StStop;
        end
        StStop: begin
          if (sample_vld) stp_bad_q <= !sample_bit;
          if (bit_end) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            if (!par_bad_q && !stp_bad_q) begin
              p_data_q     <= shift_q;
              data_valid_q <= 1'b1;
            end else begin
              par_err_q <= par_bad_q;
              stp_err_q <= stp_bad_q;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign p_data_o     = p_data_q;
  assign data_valid_o = data_valid_q;
  assign par_err_o    = par_err_q;
  assign stp_err_o    = stp_err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: frame-level line model checked every cycle plus literal pins.
module tb_uart_rx_fsm;
  import uart_pkg::*;

  localparam int MaxLen = 1024;

`ifdef UART_RX_MAJ_VOTE_EN
  localparam bit Vote = 1'b1;
`else
  localparam bit Vote = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err, busy;

  always #5 CLK = ~CLK;

  uart_rx_fsm dut (
    .CLK          (CLK),
    .RST          (RST),
    .rx_in_i      (rx_in),
    .par_en_i     (par_en),
    .par_typ_i    (par_typ),
    .prescale_i   (prescale),
    .p_data_o     (p_data),
    .data_valid_o (data_valid),
    .par_err_o    (par_err),
    .stp_err_o    (stp_err),
    .busy_o       (busy)
  );

  always @(negedge CLK) begin
    if (RST) assert (prescale_legal(prescale)) else $error("illegal PRESCALE %0d", prescale);
  end

  bit       line [MaxLen];
  int       len;
  bit       e_dv [MaxLen], e_pe [MaxLen], e_se [MaxLen], e_busy [MaxLen];
  bit [7:0] e_new [MaxLen], e_pd [MaxLen];
  bit       g_dv [MaxLen], g_pe [MaxLen], g_se [MaxLen], g_busy [MaxLen];
  bit [7:0] g_pd [MaxLen];
  int       checks = 0;
  int       failures = 0;

  task automatic check(input string name, input int c, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got 'h%0h expected 'h%0h", name, c, got, exp);
    end
  endtask

  task automatic push(input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      if (len < MaxLen) begin
        line[len] = b;
        len++;
      end
    end
  endtask

  task automatic add_frame(input logic [7:0] d, input bit with_par, input bit par_bit,
                           input bit stop_bit, input int p);
    push(1'b0, p);
    for (int k = 0; k < 8; k++) push(d[k], p);
    if (with_par) push(par_bit, p);
    push(stop_bit, p);
  endtask

  function automatic bit get(input int i);
    return (i < len) ? line[i] : 1'b1;
  endfunction

  // Value of bit k of a frame whose start edge is at cycle s.
  function automatic bit samp(input int s, input int k, input int p);
    int  base;
    bit  a, b, c;
    base = s + k * p + p / 2;
    a = get(base - 1);
    b = get(base);
    c = get(base + 1);
    return Vote ? ((a & b) | (a & c) | (b & c)) : b;
  endfunction

  task automatic build_model(input int p, input bit pe, input bit pt);
    int       t, s, f, e, nb;
    bit [7:0] d, pd;
    bit       bad_par, bad_stp;
    for (int i = 0; i < MaxLen; i++) begin
      e_dv[i] = 0; e_pe[i] = 0; e_se[i] = 0; e_busy[i] = 0; e_new[i] = 0; e_pd[i] = 0;
    end
    nb = 10 + int'(pe);
    t  = 0;
    while (t < len) begin
      if (get(t)) begin
        t++;
      end else begin
        s = t;
        if (samp(s, 0, p)) begin
          e = s + p / 2 + int'(Vote);
          for (int c = s + 1; c <= e && c < MaxLen; c++) e_busy[c] = 1;
          t = e + 1;
        end else begin
          for (int k = 0; k < 8; k++) d[k] = samp(s, k + 1, p);
          bad_par = pe && (samp(s, 9, p) != ((^d) ^ (pt == ParOdd)));
          bad_stp = !samp(s, nb - 1, p);
          f = s + nb * p;
          for (int c = s + 1; c < f && c < MaxLen; c++) e_busy[c] = 1;
          if (f < MaxLen) begin
            if (!bad_par && !bad_stp) begin
              e_dv[f]  = 1;
              e_new[f] = d;
            end else begin
              e_pe[f] = bad_par;
              e_se[f] = bad_stp;
            end
          end
          t = f;
        end
      end
    end
    pd = 0;
    for (int c = 0; c < MaxLen; c++) begin
      if (e_dv[c]) pd = e_new[c];
      e_pd[c] = pd;
    end
  endtask

  task automatic run(input int p, input bit pe, input bit pt, input int abort_at,
                     input int flip_at);
    build_model(p, pe, pt);
    RST      = 1'b0;
    rx_in    = 1'b1;
    prescale = 6'(p);
    par_en   = pe;
    par_typ  = pt;
    @(negedge CLK);
    check("reset_state", -1, {p_data, data_valid, par_err, stp_err, busy}, 0);
    @(posedge CLK);
    #1 RST = 1'b1;
    for (int c = 0; c < len; c++) begin
      @(posedge CLK);
      #1 rx_in = get(c);
      if (c == flip_at) begin
        par_en   = ~pe;
        prescale = (p == 8) ? 6'd16 : 6'd8;
      end
      if (c == abort_at) begin
        RST = 1'b0;
        #1;
        check("abort_reset", c, {p_data, data_valid, par_err, stp_err, busy}, 0);
        break;
      end
      @(negedge CLK);
      g_dv[c] = data_valid; g_pe[c] = par_err; g_se[c] = stp_err;
      g_busy[c] = busy; g_pd[c] = p_data;
      check("data_valid", c, data_valid, e_dv[c]);
      check("par_err", c, par_err, e_pe[c]);
      check("stp_err", c, stp_err, e_se[c]);
      check("busy", c, busy, e_busy[c]);
      check("p_data", c, p_data, e_pd[c]);
    end
  endtask

  initial begin
    // Even parity, 0xA5 then 0x3C back-to-back.
    len = 0;
    push(1'b1, 2);
    add_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8);
    add_frame(8'h3C, 1'b1, 1'b0, 1'b1, 8);
    push(1'b1, 20);
    run(8, 1'b1, 1'b0, -1, -1);
    check("t1_dv_lit", 90, g_dv[90], 1);
    check("t1_pd_lit", 90, g_pd[90], 'hA5);
    check("t1_pe_lit", 90, g_pe[90], 0);
    check("t1_b2b_dv_lit", 178, g_dv[178], 1);
    check("t1_b2b_pd_lit", 178, g_pd[178], 'h3C);

    // Odd parity at P=16: good 0x3C, then 0x3C with wrong parity.
    len = 0;
    push(1'b1, 2);
    add_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
    push(1'b1, 5);
    add_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16);
    push(1'b1, 20);
    run(16, 1'b1, 1'b1, -1, -1);
    check("t2_good_dv_lit", 178, g_dv[178], 1);
    check("t2_pe_lit", 359, g_pe[359], 1);
    check("t2_dv_lit", 359, g_dv[359], 0);
    check("t2_pd_held_lit", 359, g_pd[359], 'h3C);

    // No parity, stop bit 0; config inputs changed mid-frame.
    len = 0;
    push(1'b1, 2);
    add_frame(8'h5A, 1'b0, 1'b0, 1'b0, 8);
    push(1'b1, 20);
    run(8, 1'b0, 1'b0, -1, 20);
    check("t3_se_lit", 82, g_se[82], 1);
    check("t3_dv_lit", 82, g_dv[82], 0);
    check("t3_pe_lit", 82, g_pe[82], 0);

    // Start-bit glitch.
    len = 0;
    push(1'b1, 2);
    push(1'b0, 3);
    push(1'b1, 20);
    run(8, 1'b0, 1'b0, -1, -1);
    check("t4_busy_lit", 3, g_busy[3], 1);
    check("t4_idle_lit", 12, g_busy[12], 0);

    // Reset mid-frame, then a clean 0x12.
    len = 0;
    push(1'b1, 2);
    add_frame(8'hFF, 1'b0, 1'b0, 1'b1, 8);
    push(1'b1, 20);
    run(8, 1'b0, 1'b0, 40, -1);
    len = 0;
    push(1'b1, 2);
    add_frame(8'h12, 1'b0, 1'b0, 1'b1, 8);
    push(1'b1, 20);
    run(8, 1'b0, 1'b0, -1, -1);
    check("t5_dv_lit", 82, g_dv[82], 1);
    check("t5_pd_lit", 82, g_pd[82], 'h12);

    // One-cycle glitch at the mid point of data bit 3.
    len = 0;
    push(1'b1, 2);
    add_frame(8'h00, 1'b0, 1'b0, 1'b1, 16);
    line[2 + 4 * 16 + 8] = 1'b1;
    push(1'b1, 20);
    run(16, 1'b0, 1'b0, -1, -1);
    check("t6_dv_lit", 162, g_dv[162], 1);
    check("t6_pd_lit", 162, g_pd[162], Vote ? 'h00 : 'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
